// File: rtl/cpu_pkg.sv
// Shared fetch-unit types and defaults: state encoding, reset PC, ROM size.
// Also holds the saturating counter helper used by the fetch controller.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam int          DEF_ROM_WORDS = 32;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: jump target, then taken branch, then PC+4.
// Zero latency; when neither redirect applies the immediate bits never reach the output.
module npc_calc (
  input  logic [31:0] i_pc_plus4,
  input  logic [25:0] i_imm26,
  input  logic        i_branch,
  input  logic        i_branch_ne,
  input  logic        i_zero,
  input  logic        i_jump,
  output logic [31:0] o_next_pc
);

  logic        w_taken;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;

  assign w_taken         = (i_branch & i_zero) | (i_branch_ne & ~i_zero);
  assign w_branch_target = i_pc_plus4 + {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};
  assign w_jump_target   = {i_pc_plus4[31:28], i_imm26, 2'b00};

  always_comb begin
    o_next_pc = i_pc_plus4;
    if (i_jump) begin
      o_next_pc = w_jump_target;
    end else if (w_taken) begin
      o_next_pc = w_branch_target;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter, run/stall/halt control and saturating instruction counter.
// Redirects land on the next rising edge; an out-of-range next PC halts until Reset.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          ROM_WORDS = DEF_ROM_WORDS
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Inst,
  input  logic        Branch,
  input  logic        BranchNe,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        Stall,
  output logic [31:0] Addr,
  output logic [31:0] PCPlus4,
  output logic        Halted,
  output logic [15:0] InstCount
);

  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

  fetch_state_t r_state;
  logic [31:0]  r_addr;
  logic         r_halted;
  logic [15:0]  r_inst_count;

  logic [31:0]  w_next_pc;
  logic         w_in_range;
  logic [5:0]   w_unused_opcode;

  assign w_unused_opcode = Inst[31:26];
  assign PCPlus4         = r_addr + 32'd4;
  assign w_in_range      = (w_next_pc < ROM_BYTES);

  npc_calc u_npc_calc (
    .i_pc_plus4  (PCPlus4),
    .i_imm26     (Inst[25:0]),
    .i_branch    (Branch),
    .i_branch_ne (BranchNe),
    .i_zero      (Zero),
    .i_jump      (Jump),
    .o_next_pc   (w_next_pc)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_RUN;
      r_addr       <= RESET_PC;
      r_halted     <= 1'b0;
      r_inst_count <= 16'd0;
    end else begin
      case (r_state)
        ST_RUN, ST_STALL: begin
          if (Stall) begin
            r_state <= ST_STALL;
          end else if (w_in_range) begin
            r_state      <= ST_RUN;
            r_addr       <= w_next_pc;
            r_inst_count <= sat_inc16(r_inst_count);
          end else begin
            // The instruction at the last legal address still retires.
            r_state      <= ST_HALT;
            r_halted     <= 1'b1;
            r_inst_count <= sat_inc16(r_inst_count);
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_HALT;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign Addr      = r_addr;
  assign Halted    = r_halted;
  assign InstCount = r_inst_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: vector table plus reset/halt/saturation sequences.
module tb_pc_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] Inst;
  logic        Branch, BranchNe, Zero, Jump, Stall;
  logic [31:0] Addr, PCPlus4;
  logic        Halted;
  logic [15:0] InstCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic        br;
    logic        bne;
    logic        zero;
    logic        jmp;
    logic        stall;
    logic [31:0] e_addr;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  pc_fetch_ctrl dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Inst      (Inst),
    .Branch    (Branch),
    .BranchNe  (BranchNe),
    .Zero      (Zero),
    .Jump      (Jump),
    .Stall     (Stall),
    .Addr      (Addr),
    .PCPlus4   (PCPlus4),
    .Halted    (Halted),
    .InstCount (InstCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] ea, input logic eh, input logic [15:0] ec);
    chk({tag, " addr"}, Addr, ea);
    chk({tag, " halted"}, {31'd0, Halted}, {31'd0, eh});
    chk({tag, " count"}, {16'd0, InstCount}, {16'd0, ec});
  endtask

  task automatic drive(input logic [31:0] inst, input logic br, input logic bne,
                       input logic zero, input logic jmp, input logic stall);
    Inst = inst; Branch = br; BranchNe = bne; Zero = zero; Jump = jmp; Stall = stall;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    //            inst           br   bne  zero jmp  stall addr          halt cnt
    vecs[0]  = '{32'hxxxx_xxxx, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h04, 1'b0, 16'd1};
    vecs[1]  = '{32'h0000_0000, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h08, 1'b0, 16'd2};
    vecs[2]  = '{32'h0000_0000, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0C, 1'b0, 16'd3};
    vecs[3]  = '{32'h0000_0000, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h10, 1'b0, 16'd4};
    vecs[4]  = '{32'h0800_001F, 1'b0,1'b0,1'b0,1'b1,1'b1, 32'h10, 1'b0, 16'd4};
    vecs[5]  = '{32'h0000_0000, 1'b0,1'b0,1'b0,1'b0,1'b1, 32'h10, 1'b0, 16'd4};
    vecs[6]  = '{32'h0000_0000, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h14, 1'b0, 16'd5};
    vecs[7]  = '{32'h0000_0000, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h18, 1'b0, 16'd6};
    vecs[8]  = '{32'h1422_0002, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h24, 1'b0, 16'd7};
    vecs[9]  = '{32'h1000_FFFF, 1'b1,1'b0,1'b0,1'b0,1'b0, 32'h28, 1'b0, 16'd8};
    vecs[10] = '{32'h0800_000D, 1'b1,1'b0,1'b1,1'b1,1'b0, 32'h34, 1'b0, 16'd9};
    vecs[11] = '{32'h1000_FFFE, 1'b1,1'b0,1'b1,1'b0,1'b0, 32'h30, 1'b0, 16'd10};
    vecs[12] = '{32'h0000_0003, 1'b1,1'b1,1'b0,1'b0,1'b0, 32'h40, 1'b0, 16'd11};
    vecs[13] = '{32'h0000_FFFF, 1'b0,1'b1,1'b1,1'b0,1'b0, 32'h44, 1'b0, 16'd12};
    vecs[14] = '{32'h0800_001F, 1'b0,1'b0,1'b0,1'b1,1'b0, 32'h7C, 1'b0, 16'd13};
    vecs[15] = '{32'h0000_0000, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h7C, 1'b1, 16'd14};
    vecs[16] = '{32'h0800_0000, 1'b1,1'b0,1'b1,1'b1,1'b0, 32'h7C, 1'b1, 16'd14};
    vecs[17] = '{32'h0000_0000, 1'b0,1'b0,1'b0,1'b0,1'b1, 32'h7C, 1'b1, 16'd14};

    Reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk_state("reset", 32'h0, 1'b0, 16'd0);
    chk("reset pcplus4", PCPlus4, 32'h4);
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].inst, vecs[i].br, vecs[i].bne, vecs[i].zero, vecs[i].jmp, vecs[i].stall);
      step();
      chk_state($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_halt, vecs[i].e_cnt);
      chk($sformatf("v%0d pcplus4", i), PCPlus4, vecs[i].e_addr + 32'd4);
    end

    // Asynchronous reset mid-cycle while halted, then first update on next edge.
    drive(32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    chk_state("halt async reset", 32'h0, 1'b0, 16'd0);
    Reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_state("after reset", 32'h4, 1'b0, 16'd1);

    // Reset while stalled.
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_state("stall hold", 32'h4, 1'b0, 16'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk_state("stall async reset", 32'h0, 1'b0, 16'd0);
    Reset = 1'b0;

    // Backward branch from 0 wraps to 0xFFFFFFFC, which is out of range.
    drive(32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_state("branch wrap halt", 32'h0, 1'b1, 16'd1);

    // Jump just past the last legal word halts.
    pulse_reset();
    drive(32'h0800_0020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_state("jump oob halt", 32'h0, 1'b1, 16'd1);

    // Counter saturation: jump-to-0 loop keeps the PC legal while counting.
    pulse_reset();
    drive(32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 65534; n++) step();
    chk_state("count fffe", 32'h0, 1'b0, 16'hFFFE);
    for (int n = 0; n < 3; n++) step();
    chk_state("count sat", 32'h0, 1'b0, 16'hFFFF);
    drive(32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk_state("count sat stall", 32'h0, 1'b0, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address loaded into the PC on reset.
REQ-002 Parameter ROM_WORDS, default 32, number of instruction-memory words; the legal byte range is 0 to ROM_WORDS*4-4.
REQ-003 Port CLK, input, 1, the single system clock; all state updates on the rising edge.
REQ-004 Port Reset, input, 1, asynchronous, active-high reset.
REQ-005 Port Inst, input, 32, instruction word returned by instruction memory for the current Addr.
REQ-006 Port Branch, input, 1, current instruction is beq.
REQ-007 Port BranchNe, input, 1, current instruction is bne.
REQ-008 Port Zero, input, 1, ALU zero flag for the current instruction.
REQ-009 Port Jump, input, 1, current instruction is j.
REQ-010 Port Stall, input, 1, hold the PC this cycle.
REQ-011 Port Addr, output, 32, current PC, driven to instruction memory.
REQ-012 Port PCPlus4, output, 32, Addr+4, combinational.
REQ-013 Port Halted, output, 1, the fetch unit has stopped on an out-of-range next PC.
REQ-014 Port InstCount, output, 16, saturating count of instructions executed since reset.

Function
REQ-015 States: RUN, STALL, HALT, held in a registered state variable.
REQ-016 Taken = (Branch & Zero) | (BranchNe & ~Zero); if Branch and BranchNe are both set, either true condition makes Taken true.
REQ-017 BranchTarget = PCPlus4 + (sign-extended Inst[15:0] << 2), 32-bit with wrap-around.
REQ-018 JumpTarget = {PCPlus4[31:28], Inst[25:0], 2'b00}.
REQ-019 NextPC priority, highest first: Jump -> JumpTarget; Taken -> BranchTarget; otherwise PCPlus4.
REQ-020 In RUN with Stall=0: if NextPC < ROM_WORDS*4, Addr <= NextPC, InstCount increments, and the state stays RUN.
REQ-021 In RUN with Stall=0 and NextPC >= ROM_WORDS*4: Addr holds, InstCount increments (the current instruction completes), Halted <= 1, and the state goes to HALT.
REQ-022 In RUN with Stall=1: Addr and InstCount hold, and the state goes to STALL.
REQ-023 In STALL: the state is held while Stall=1; with Stall=0 the block evaluates exactly as in RUN that cycle (REQ-020/021) and the state goes to RUN or HALT.
REQ-024 HALT is absorbing: Addr, InstCount and Halted=1 hold regardless of any input until Reset.
REQ-025 InstCount saturates at 16'hFFFF and does not wrap.
REQ-026 Latency: a redirect takes effect on the next rising edge; Addr is always a registered output.
REQ-027 When Jump=0 and Taken=0, the contents of Inst (including X) do not affect state.

Reset
REQ-028 While Reset=1, immediately and asynchronously: Addr=RESET_PC, state=RUN, Halted=0, InstCount=0.
REQ-029 Reset asserted during STALL or HALT gives the same values as REQ-028; the first update after Reset deasserts happens on the next rising edge.

Structure
REQ-030 The state encoding, RESET_PC default and ROM_WORDS default live in the shared package cpu_pkg.
REQ-031 Next-PC arithmetic (REQ-016 to REQ-019) is a combinational sub-module npc_calc; state, PC and counter stay in pc_fetch_ctrl.

Verification
REQ-032 Reset then 3 idle cycles -> Addr 0x00, 0x04, 0x08, 0x0C; InstCount=3.
REQ-033 Addr=0x18, Inst=0x14220002, BranchNe=1, Zero=0 -> Addr=0x24 next cycle; Addr=0x24, Branch=1, Zero=0 -> Addr=0x28.
REQ-034 Addr=0x28, Inst=0x0800000D, Jump=1, Branch=1, Zero=1 -> Addr=0x34 (Jump wins).
REQ-035 Stall=1 for 2 cycles at Addr=0x10 -> Addr=0x10 and InstCount unchanged; Stall=0 -> Addr=0x14.
REQ-036 Addr=0x7C with no redirect -> Addr stays 0x7C, Halted=1 and holds under Jump; Reset asserted mid-cycle -> Addr=0x00, Halted=0 at once.
REQ-037 Force InstCount to 0xFFFE, run 3 cycles -> InstCount=0xFFFF and holds.
